// File: rtl/mole_if.sv
// mole_if: board-side bundle for the whack-a-mole scheduler.
//   start       : one-cycle game start pulse (into the scheduler)
//   sw[15:0]    : board switch levels (into the scheduler)
//   LED[15:0]   : mole display (from the scheduler)
//   score_count : hits this game, saturating at 63 (from the scheduler)
//   misses      : misses this game (from the scheduler)
//   game_over   : high while the game is finished (from the scheduler)
// The master side is the board/stimulus; the slave side is the scheduler.
interface mole_if;
    logic        start;
    logic [15:0] sw;
    logic [15:0] LED;
    logic [5:0]  score_count;
    logic [1:0]  misses;
    logic        game_over;

    modport master (
        output start, sw,
        input  LED, score_count, misses, game_over
    );

    modport slave (
        input  start, sw,
        output LED, score_count, misses, game_over
    );
endinterface

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game controller.
// Picks a mole hole from a free-running 16-bit Galois LFSR (never the same
// hole twice in a row), lights it for TIMEOUT_CYCLES, classifies switch
// toggles as hits or misses, leaves GAP_CYCLES dark between moles and ends
// the game after ROUNDS moles or MAX_MISSES misses.
// Ports:
//   clk   : system clock, all logic on the rising edge
//   reset : synchronous active-high reset
//   bus   : mole_if slave (start, sw in; LED, score_count, misses, game_over out)
// All outputs are driven straight from registers.
module mole_scheduler #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int GAP_CYCLES     = 10_000_000,
    parameter int MAX_MISSES     = 3,
    parameter int ROUNDS         = 32
) (
    input  logic  clk,
    input  logic  reset,
    mole_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PICK = 3'd1,
        S_SHOW = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 in a right-shifting register.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD     = 32'(GAP_CYCLES - 1);
    localparam logic [1:0]  MISS_LIMIT   = 2'(MAX_MISSES);
    localparam logic [5:0]  ROUND_LIMIT  = 6'(ROUNDS);

    state_t      r_state;
    logic [15:0] r_sw_q;
    logic [15:0] r_lfsr;
    logic [15:0] r_led;
    logic [3:0]  r_idx;
    logic [3:0]  r_prev_idx;
    logic [5:0]  r_round;
    logic [5:0]  r_score;
    logic [1:0]  r_misses;
    logic        r_game_over;
    logic [31:0] r_timer;

    logic [15:0] w_toggle;
    logic [15:0] w_target;
    logic [15:0] w_lfsr_next;
    logic [3:0]  w_pick;
    logic        w_hit;
    logic        w_wrong;
    logic        w_timeout;
    logic        w_end_mole;
    logic [1:0]  w_misses_next;
    logic [5:0]  w_round_next;
    logic [5:0]  w_score_next;
    logic        w_last;

    // Toggle detection, mole pick and per-cycle SHOW classification.
    always_comb begin
        w_toggle      = bus.sw ^ r_sw_q;
        w_target      = 16'h0001 << r_idx;
        w_lfsr_next   = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
        // Bumping by one on a repeat guarantees consecutive moles differ.
        w_pick        = (r_lfsr[3:0] == r_prev_idx) ? (r_lfsr[3:0] + 4'd1) : r_lfsr[3:0];
        w_hit         = (w_toggle == w_target);
        w_wrong       = (w_toggle != 16'h0000) && !w_hit;
        // A toggle in the last lit cycle is classified, not treated as a timeout.
        w_timeout     = (w_toggle == 16'h0000) && (r_timer == 32'd0);
        w_end_mole    = w_hit || w_wrong || w_timeout;
        w_misses_next = (w_wrong || w_timeout) ? (r_misses + 2'd1) : r_misses;
        w_round_next  = r_round + 6'd1;
        w_score_next  = (r_score == 6'd63) ? r_score : (r_score + 6'd1);
        w_last        = (w_misses_next == MISS_LIMIT) || (w_round_next == ROUND_LIMIT);
    end

    // Game FSM with registered outputs, switch history and free-running LFSR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sw_q      <= bus.sw;
            r_lfsr      <= LFSR_SEED;
            r_led       <= 16'h0000;
            r_idx       <= 4'd0;
            r_prev_idx  <= 4'd0;
            r_round     <= 6'd0;
            r_score     <= 6'd0;
            r_misses    <= 2'd0;
            r_game_over <= 1'b0;
            r_timer     <= 32'd0;
        end else begin
            r_sw_q <= bus.sw;
            r_lfsr <= w_lfsr_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_score     <= 6'd0;
                        r_misses    <= 2'd0;
                        r_round     <= 6'd0;
                        r_led       <= 16'h0000;
                        r_game_over <= 1'b0;
                        r_state     <= S_PICK;
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_PICK: begin
                    r_idx   <= w_pick;
                    r_led   <= 16'h0001 << w_pick;
                    r_timer <= TIMEOUT_LOAD;
                    r_state <= S_SHOW;
                end
                S_SHOW: begin
                    if (w_end_mole) begin
                        if (w_hit) begin
                            r_score <= w_score_next;
                        end else begin
                            r_score <= r_score;
                        end
                        r_misses   <= w_misses_next;
                        r_round    <= w_round_next;
                        r_prev_idx <= r_idx;
                        if (w_last) begin
                            r_led       <= 16'hFFFF;
                            r_game_over <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_led   <= 16'h0000;
                            r_timer <= GAP_LOAD;
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                S_GAP: begin
                    // Toggles are ignored here; r_sw_q keeps tracking sw.
                    if (r_timer == 32'd0) begin
                        r_state <= S_PICK;
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                default: begin
                    r_led       <= 16'h0000;
                    r_game_over <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.LED         = r_led;
    assign bus.score_count = r_score;
    assign bus.misses      = r_misses;
    assign bus.game_over   = r_game_over;
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: randomized self-checking bench for mole_scheduler.
// A game-level reference model (phases, countdowns and score arithmetic
// taken from the game rules) predicts the outputs after every edge.
module tb_mole_scheduler;
    localparam int TO   = 8;
    localparam int GP   = 4;
    localparam int MAXM = 3;
    localparam int RND  = 4;
    localparam int P_IDLE = 0, P_PICK = 1, P_SHOW = 2, P_GAP = 3, P_DONE = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    mole_if bus ();

    int checks   = 0;
    int failures = 0;

    int          m_phase, m_timer, m_idx, m_prev, m_round, m_score, m_miss;
    logic [15:0] m_lfsr, m_swq, m_led;
    logic        m_go;

    mole_scheduler #(
        .TIMEOUT_CYCLES(TO),
        .GAP_CYCLES    (GP),
        .MAX_MISSES    (MAXM),
        .ROUNDS        (RND)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    function automatic logic [24:0] dut_out();
        return {bus.LED, bus.score_count, bus.misses, bus.game_over};
    endfunction

    function automatic logic [24:0] model_out();
        return {m_led, 6'(m_score), 2'(m_miss), m_go};
    endfunction

    // Reference model: applies the game rules for one clock edge.
    task automatic model_edge();
        logic [15:0] tog;
        logic [15:0] lf;
        tog   = bus.sw ^ m_swq;
        m_swq = bus.sw;
        if (reset) begin
            m_phase = P_IDLE; m_lfsr = 16'hACE1; m_led = 16'h0; m_go = 1'b0;
            m_score = 0; m_miss = 0; m_round = 0; m_prev = 0; m_idx = 0; m_timer = 0;
            return;
        end
        lf     = m_lfsr;
        m_lfsr = lfsr_adv(m_lfsr);
        case (m_phase)
            P_IDLE, P_DONE: if (bus.start) begin
                m_score = 0; m_miss = 0; m_round = 0; m_go = 1'b0; m_led = 16'h0;
                m_phase = P_PICK;
            end
            P_PICK: begin
                m_idx = int'(lf[3:0]);
                if (m_idx == m_prev) m_idx = (m_idx + 1) % 16;
                m_timer = TO - 1;
                m_led   = 16'h0001 << m_idx;
                m_phase = P_SHOW;
            end
            P_SHOW: begin
                if (tog == 16'h0 && m_timer != 0) begin
                    m_timer--;
                end else begin
                    if (tog == (16'h0001 << m_idx)) m_score = (m_score < 63) ? m_score + 1 : 63;
                    else m_miss++;
                    m_round++;
                    m_prev = m_idx;
                    if (m_miss == MAXM || m_round == RND) begin
                        m_phase = P_DONE; m_led = 16'hFFFF; m_go = 1'b1;
                    end else begin
                        m_phase = P_GAP; m_timer = GP - 1; m_led = 16'h0;
                    end
                end
            end
            P_GAP: if (m_timer == 0) m_phase = P_PICK; else m_timer--;
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.start = 1'b0; bus.sw = 16'($urandom);
        tick(); tick();
        checks++;
        if (dut_out() !== 25'd0) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", dut_out(), 25'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++; $display("FAIL reset_idle got=%h exp=%h", dut_out(), model_out());
            end
        end
    endtask

    task automatic test_timeouts();
        int run; logic [15:0] last_lit; bit done;
        run = 0; last_lit = 16'h0; done = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (dut_out() !== 25'd0) begin
            failures++; $display("FAIL timeout_start got=%h exp=%h", dut_out(), 25'd0);
        end
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++; $display("FAIL timeout_cycle got=%h exp=%h", dut_out(), model_out());
            end
            if (bus.LED != 16'h0 && bus.LED != 16'hFFFF) begin
                if (run == 0) begin
                    checks++;
                    if (bus.LED === last_lit) begin
                        failures++; $display("FAIL timeout_repeat got=%h prev=%h", bus.LED, last_lit);
                    end
                    last_lit = bus.LED;
                end
                run++;
            end else begin
                if (run != 0) begin
                    checks++;
                    if (run != TO) begin
                        failures++; $display("FAIL timeout_lit_len got=%0d exp=%0d", run, TO);
                    end
                end
                run = 0;
            end
            done = (bus.game_over === 1'b1);
        end
        checks++;
        if (dut_out() !== {16'hFFFF, 6'd0, 2'd3, 1'b1}) begin
            failures++; $display("FAIL timeout_end got=%h exp=%h", dut_out(), {16'hFFFF, 6'd0, 2'd3, 1'b1});
        end
    endtask

    task automatic test_hits();
        int pre; bit flipped, done; logic [15:0] last_lit, prev_led;
        flipped = 1'b0; done = 1'b0; last_lit = 16'h0; prev_led = 16'h0; pre = 0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (dut_out() !== model_out()) begin
            failures++; $display("FAIL hits_start got=%h exp=%h", dut_out(), model_out());
        end
        for (int c = 0; c < 300 && !done; c++) begin
            if (m_phase == P_SHOW && m_timer == TO - 4) begin
                bus.sw = bus.sw ^ m_led; pre = m_score; flipped = 1'b1;
            end
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++; $display("FAIL hits_cycle got=%h exp=%h", dut_out(), model_out());
            end
            if (flipped) begin
                checks++;
                if (int'(bus.score_count) != pre + 1) begin
                    failures++; $display("FAIL hits_increment got=%0d exp=%0d", bus.score_count, pre + 1);
                end
                flipped = 1'b0;
            end
            if (prev_led == 16'h0 && bus.LED != 16'h0 && bus.LED != 16'hFFFF) begin
                checks++;
                if (bus.LED === last_lit) begin
                    failures++; $display("FAIL hits_repeat got=%h prev=%h", bus.LED, last_lit);
                end
                last_lit = bus.LED;
            end
            prev_led = bus.LED;
            done = (bus.game_over === 1'b1);
        end
        checks++;
        if (dut_out() !== {16'hFFFF, 6'd4, 2'd0, 1'b1}) begin
            failures++; $display("FAIL hits_end got=%h exp=%h", dut_out(), {16'hFFFF, 6'd4, 2'd0, 1'b1});
        end
    endtask

    task automatic test_wrong();
        int stage, b; bit flipped, done; logic [15:0] other;
        stage = 0; flipped = 1'b0; done = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            flipped = 1'b0;
            if (m_phase == P_SHOW && m_timer == TO - 3 && stage < 2) begin
                b = m_idx;
                while (b == m_idx) b = int'($urandom_range(15, 0));
                other = 16'h0001 << b;
                bus.sw = bus.sw ^ ((stage == 0) ? other : (other | m_led));
                stage++; flipped = 1'b1;
            end
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++; $display("FAIL wrong_cycle got=%h exp=%h", dut_out(), model_out());
            end
            if (flipped) begin
                checks++;
                if ({bus.LED, bus.score_count, bus.misses} !== {16'h0, 6'd0, 2'(stage)}) begin
                    failures++; $display("FAIL wrong_whack got=%h exp=%h",
                        {bus.LED, bus.score_count, bus.misses}, {16'h0, 6'd0, 2'(stage)});
                end
            end
            done = (bus.game_over === 1'b1);
        end
        checks++;
        if (dut_out() !== {16'hFFFF, 6'd0, 2'd3, 1'b1}) begin
            failures++; $display("FAIL wrong_end got=%h exp=%h", dut_out(), {16'hFFFF, 6'd0, 2'd3, 1'b1});
        end
    endtask

    task automatic test_last_cycle();
        int flag, gap_at; bit hit_done, gap_done, done;
        hit_done = 1'b0; gap_done = 1'b0; done = 1'b0;
        gap_at = int'($urandom_range(GP - 1, 0));
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            flag = 0;
            if (m_phase == P_SHOW && m_timer == 0 && !hit_done) begin
                bus.sw = bus.sw ^ m_led; hit_done = 1'b1; flag = 1;
            end else if (m_phase == P_GAP && m_timer == gap_at && hit_done && !gap_done) begin
                bus.sw = bus.sw ^ 16'($urandom_range(65535, 1)); gap_done = 1'b1; flag = 2;
            end
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++; $display("FAIL last_cycle got=%h exp=%h", dut_out(), model_out());
            end
            if (flag != 0) begin
                checks++;
                if ({bus.score_count, bus.misses, bus.game_over} !== {6'd1, 2'd0, 1'b0}) begin
                    failures++; $display("FAIL last_%s got=%h exp=%h", (flag == 1) ? "hit" : "gap",
                        {bus.score_count, bus.misses, bus.game_over}, {6'd1, 2'd0, 1'b0});
                end
            end
            done = (bus.game_over === 1'b1);
        end
        checks++;
        if (dut_out() !== {16'hFFFF, 6'd1, 2'd3, 1'b1}) begin
            failures++; $display("FAIL last_end got=%h exp=%h", dut_out(), {16'hFFFF, 6'd1, 2'd3, 1'b1});
        end
    endtask

    task automatic test_reset_midgame();
        bit hit_reset, sent, done;
        hit_reset = 1'b0; sent = 1'b0; done = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int c = 0; c < 50 && !hit_reset; c++) begin
            if (m_phase == P_SHOW && m_timer == TO - 3) begin
                reset = 1'b1; hit_reset = 1'b1;
            end
            tick();
            reset = 1'b0;
        end
        checks++;
        if (dut_out() !== 25'd0 || !hit_reset) begin
            failures++; $display("FAIL midgame_reset got=%h exp=%h", dut_out(), 25'd0);
        end
        tick(); tick();
        checks++;
        if (dut_out() !== 25'd0) begin
            failures++; $display("FAIL reset_stays_idle got=%h exp=%h", dut_out(), 25'd0);
        end
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (m_phase == P_SHOW && m_timer == TO - 2 && !sent) begin
                bus.start = 1'b1; sent = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            checks++;
            if (dut_out() !== model_out()) begin
                failures++; $display("FAIL start_in_show got=%h exp=%h", dut_out(), model_out());
            end
            done = (bus.game_over === 1'b1);
        end
        checks++;
        if (!done || bus.misses !== 2'd3) begin
            failures++; $display("FAIL show_start_ignored got=%0d exp=%0d", bus.misses, 3);
        end
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (dut_out() !== 25'd0) begin
            failures++; $display("FAIL done_restart got=%h exp=%h", dut_out(), 25'd0);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(99, 0));
            bus.start = (r < 4);
            reset = ($urandom_range(299, 0) == 0);
            if (r >= 70 && r < 85 && m_phase == P_SHOW) bus.sw = bus.sw ^ m_led;
            else if (r >= 85) bus.sw = bus.sw ^ 16'($urandom);
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++; $display("FAIL random_cycle got=%h exp=%h", dut_out(), model_out());
            end
        end
        bus.start = 1'b0; reset = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sw    = 16'h0;
        test_reset();
        test_timeouts();
        test_hits();
        test_wrong();
        test_last_cycle();
        test_reset_midgame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Game controller for the Whack-a-Mole board: sequences the 16 switch/LED "holes" under a timed, pseudo-random schedule instead of a fixed left-to-right walk. It picks a mole position from an LFSR, lights it for a bounded time window, and classifies switch toggles as hits or misses. It also keeps score and a miss count, and ends the game after a set number of rounds or misses. It drives the board LEDs and the score display input directly and sits between the switch inputs and the seven-segment score path.

## Interface
- TIMEOUT_CYCLES, 50_000_000: cycles a mole stays lit (≥2).
- GAP_CYCLES, 10_000_000: dark cycles between moles (≥1).
- MAX_MISSES, 3: misses that end the game (1..3).
- ROUNDS, 32: moles per game (1..63).

Ports:
- clk, input, 1: system clock. One clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse; starts a game from IDLE or DONE.
- sw, input, 16: board switches, level signals; any toggle is a whack.
- LED, output, 16: mole display.
- score_count, output, 6: hits this game, saturating at 63.
- misses, output, 2: misses this game.
- game_over, output, 1: high in DONE.

## Operation
- sw_q is a register that samples sw every cycle. toggle = sw ^ sw_q. A hole counts as whacked when its switch is flipped either way.
- lfsr is a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1, seeded 16'hACE1 on reset. It advances every cycle, free-running, and is not cleared by start.
- idx is the current mole index (4 bits). prev_idx is the last index used. round is a 6-bit count of completed moles.

FSM states:
- IDLE: LED=0. On start: clear score_count, misses, round; go to PICK.
- PICK (1 cycle): idx = lfsr[3:0]. If that equals prev_idx, idx = lfsr[3:0]+1 mod 16. Load timer = TIMEOUT_CYCLES-1. Go to SHOW.
- SHOW: LED = 1<<idx. Evaluate each cycle in priority order:
  - Hit: toggle == (1<<idx) exactly. score_count +1, saturating at 63.
  - Wrong whack: toggle != 0 and not exactly the target bit (includes target plus others). misses +1.
  - Timeout: toggle == 0 and timer == 0. misses +1.
  - Otherwise: timer −1, stay in SHOW.
  - On hit, wrong whack, or timeout: round +1 and prev_idx = idx. Then:
    - if misses reaches MAX_MISSES or round reaches ROUNDS, go to DONE;
    - else load gap timer = GAP_CYCLES-1 and go to GAP.
- GAP: LED=0. Toggles are ignored, but sw_q still tracks sw. Count down; at 0 go to PICK.
- DONE: LED=16'hFFFF, game_over=1. score_count and misses hold. start clears counters and goes to PICK. game_over drops the same edge.
- start is ignored in PICK, SHOW, and GAP.
- misses never exceeds MAX_MISSES.

## Timing
- Reset values: LED=0, score_count=0, misses=0, game_over=0, state=IDLE, round=0, prev_idx=0, lfsr=16'hACE1. sw_q loads sw, so no spurious toggle after reset.
- Reset mid-game returns to IDLE at the next edge, with all outputs at their reset values.
- The edge sampling start moves to PICK. LED lights at the following edge, so start to LED takes 2 cycles.
- A mole is lit exactly TIMEOUT_CYCLES cycles if untouched.
- A hit or miss seen in cycle N updates score_count/misses, and clears LED or sets FFFF, at edge N+1. This is 1-cycle latency.
- Toggle in the timer==0 cycle: the toggle is classified normally, so a correct toggle is a hit.
- Consecutive moles never share an index.
- All outputs are registered.

## Test plan
Bench parameters: TIMEOUT_CYCLES=8, GAP_CYCLES=4, MAX_MISSES=3, ROUNDS=4.
- Reset, start, no switch activity: LED one-hot for 8 cycles, 0 for 4, repeat. misses goes 1,2,3. After the 3rd timeout, game_over=1, LED=FFFF, score_count=0.
- Flip the lit switch 3 cycles into each SHOW: score_count increments the cycle after each flip. After the 4th hit, DONE with score_count=4, misses=0. No two consecutive LED patterns are equal.
- Flip a non-lit switch during SHOW: misses=1, score_count=0, LED=0 the next cycle. Flipping the target plus one other switch in the same cycle is also a miss.
- Flip the lit switch exactly in the 8th lit cycle: counts as a hit, score_count=1, misses=0. Flip any switch during GAP: no score or miss change.
- Assert reset mid-SHOW, then pulse start during a later SHOW: reset gives all outputs zero in IDLE next cycle. The start pulse during SHOW is ignored, with round/score unchanged. A start in DONE clears counters and game_over at the next edge.
